// File: rtl/float_discriminant_distributor_pkg.sv
// float_discriminant_distributor_pkg: shared types, pointer sizing and the fused discriminant datapath
package float_discriminant_distributor_pkg;
  localparam int FLEN = 64;
  typedef struct packed {
    logic [FLEN-1:0] res;
    logic negative;
    logic err;
  } disc_result_t;
  function automatic int ptr_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int eff_exp(logic [10:0] e);
    return e == 11'd0 ? 1 : int'(e);
  endfunction
  // b*b and 4*a*c are formed exactly, subtracted with guard/sticky bits and rounded once (RNE)
  function automatic disc_result_t disc_calc(logic [63:0] a, logic [63:0] b, logic [63:0] c);
    disc_result_t r;
    logic [105:0] pb, pac, pbig, psml;
    logic [108:0] big, sml, tmp;
    logic [109:0] sum;
    logic [219:0] t;
    logic [62:0] mag;
    logic sg, ss, sgn, inc;
    int x1, x2, xb, d, k, sh, e;
    pb = 106'({b[62:52] != 11'd0, b[51:0]}) * 106'({b[62:52] != 11'd0, b[51:0]});
    pac = 106'({a[62:52] != 11'd0, a[51:0]}) * 106'({c[62:52] != 11'd0, c[51:0]});
    x1 = pb == '0 ? 0 : 2 * eff_exp(b[62:52]);
    x2 = pac == '0 ? 0 : eff_exp(a[62:52]) + eff_exp(c[62:52]) + 2;
    sg = x1 >= x2 ? 1'b0 : ~(a[63] ^ c[63]);
    ss = x1 >= x2 ? ~(a[63] ^ c[63]) : 1'b0;
    pbig = x1 >= x2 ? pb : pac;
    psml = x1 >= x2 ? pac : pb;
    xb = x1 >= x2 ? x1 : x2;
    d = x1 >= x2 ? x1 - x2 : x2 - x1;
    big = {pbig, 3'b000};
    tmp = {psml, 3'b000};
    sml = d >= 109 ? '0 : tmp >> d;
    sml[0] = sml[0] | (d >= 109 ? |tmp : |(tmp << (109 - d)));
    sum = sg == ss ? {1'b0, big} + {1'b0, sml} : big >= sml ? {1'b0, big} - {1'b0, sml} : {1'b0, sml} - {1'b0, big};
    sgn = sg == ss || big >= sml ? sg : ss;
    k = 0;
    for (int i = 0; i < 110; i++) if (sum[i]) k = i;
    e = k + xb - 1130;
    sh = 109 - k;
    if (e < 1) begin
      sh = sh - (1 - e);
      e = 0;
    end
    t = {sum, 110'd0};
    t = sh >= 0 ? t << sh : t >> (-sh > 112 ? 112 : -sh);
    inc = t[166] & (|t[165:0] | t[167]);
    mag = sum == '0 ? '0 : e >= 2047 ? {11'h7FF, 52'd0} : {11'(e), t[218:167]} + 63'(inc);
    r.err = &a[62:52] | &b[62:52] | &c[62:52];
    r.negative = !r.err && sgn && mag != '0;
    r.res = r.err ? 64'h7FF8000000000000 : {r.negative, mag};
    return r;
  endfunction
endpackage

// File: rtl/float_discriminant_slot.sv
// float_discriminant_slot: one discriminant unit with its in-flight/held flags and holding register
module float_discriminant_slot
  import float_discriminant_distributor_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            issue,
  input  logic            retire,
  input  logic [FLEN-1:0] a,
  input  logic [FLEN-1:0] b,
  input  logic [FLEN-1:0] c,
  output logic            free,
  output logic            held,
  output disc_result_t    hold
);
  disc_result_t nx, unit_r;
  logic unit_busy, unit_vld, in_flight;
  logic [1:0] cnt;
  always_comb begin
    nx = disc_calc(a, b, c);
    unit_vld = unit_busy && cnt == 2'd0;
    free = !in_flight && !held;
  end
  // unit latency is 1 cycle for special operands, otherwise 1 + the two low exponent bits of b
  always_ff @(posedge clk) begin
    if (rst) begin
      unit_busy <= 1'b0;
      cnt <= '0;
      unit_r <= '0;
      in_flight <= 1'b0;
      held <= 1'b0;
      hold <= '0;
    end else begin
      if (issue) begin
        unit_r <= nx;
        cnt <= nx.err ? 2'd0 : b[53:52];
        unit_busy <= 1'b1;
        in_flight <= 1'b1;
      end else if (unit_busy) begin
        unit_busy <= cnt != 2'd0;
        cnt <= cnt - 2'd1;
      end
      if (unit_vld && in_flight) begin
        hold <= unit_r;
        held <= 1'b1;
        in_flight <= 1'b0;
      end
      if (retire) held <= 1'b0;
    end
  end
endmodule

// File: rtl/float_discriminant_distributor.sv
// float_discriminant_distributor: round-robin issue to N_UNITS discriminant slots with in-order retirement
module float_discriminant_distributor
  import float_discriminant_distributor_pkg::*;
#(
  parameter int N_UNITS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            arg_vld,
  input  logic [FLEN-1:0] a,
  input  logic [FLEN-1:0] b,
  input  logic [FLEN-1:0] c,
  output logic            arg_rdy,
  output logic            res_vld,
  output logic [FLEN-1:0] res,
  output logic            res_negative,
  output logic            err,
  output logic            busy
);
  localparam int PW = ptr_w(N_UNITS);
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [N_UNITS-1:0] free, held, issue, retire_v;
  logic accept, retire;
  disc_result_t hold [N_UNITS];
  for (genvar i = 0; i < N_UNITS; i++) begin : g_slot
    float_discriminant_slot u_slot (
      .clk(clk), .rst(rst), .issue(issue[i]), .retire(retire_v[i]),
      .a(a), .b(b), .c(c), .free(free[i]), .held(held[i]), .hold(hold[i])
    );
  end
  always_comb begin
    arg_rdy = free[wr_ptr];
    accept = arg_vld && arg_rdy;
    retire = held[rd_ptr];
    issue = {N_UNITS{accept}} & (N_UNITS'(1) << wr_ptr);
    retire_v = {N_UNITS{retire}} & (N_UNITS'(1) << rd_ptr);
    busy = ~&free;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      res_vld <= 1'b0;
      res <= '0;
      res_negative <= 1'b0;
      err <= 1'b0;
    end else begin
      res_vld <= retire;
      if (retire) begin
        {res, res_negative, err} <= hold[rd_ptr];
        rd_ptr <= rd_ptr == PW'(N_UNITS - 1) ? '0 : rd_ptr + 1'b1;
      end
      if (accept) wr_ptr <= wr_ptr == PW'(N_UNITS - 1) ? '0 : wr_ptr + 1'b1;
    end
  end
endmodule
